// File: rtl/tcp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcp_pkg
// Description : Shared sequence-space types and helpers for the TCP endpoints.
// Revision    : 1.0 - initial release
// ============================================================================
package tcp_pkg;

    localparam int SEQ_W = 4;

    typedef logic [SEQ_W-1:0] seq_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } ack_state_t;

    // Forward distance from b to a in the mod-16 sequence space.
    function automatic seq_t seq_off(input seq_t a, input seq_t b);
        return a - b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcp_rcv_bitmap.sv
`default_nettype none
// ============================================================================
// Module      : tcp_rcv_bitmap
// Description : Out-of-order window bitmap: segment mark with tail clipping,
//               single-unit in-order advance and occupancy popcount.
// Revision    : 1.0 - initial release
// ============================================================================
module tcp_rcv_bitmap
    import tcp_pkg::*;
#(
    parameter int WIN = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_seg_val,
    input  seq_t       i_off,
    input  seq_t       i_len,
    input  logic [3:0] i_limit,
    output logic       o_adv,
    output logic       o_forced,
    output logic [3:0] o_pop,
    output logic [3:0] o_pop_nxt
);

    logic [WIN-1:0] r_bitmap;
    logic [WIN-1:0] w_mask;
    logic [WIN-1:0] w_post;
    logic [WIN-1:0] w_next;
    logic [4:0]     w_end;
    logic           w_in_win;

    function automatic logic [3:0] popcnt(input logic [WIN-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < WIN; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign w_end    = {1'b0, i_off} + {1'b0, i_len};
    assign w_in_win = i_seg_val && (i_len != '0) && ({1'b0, i_off} < {1'b0, i_limit});
    assign o_forced = i_seg_val && !w_in_win;

    // Bit i covers unit rcv_nxt+i; anything at or past the free limit is clipped.
    genvar gi;
    generate
        for (gi = 0; gi < WIN; gi++) begin : g_mask
            assign w_mask[gi] = w_in_win
                             && ({1'b0, i_off} <= 5'(gi))
                             && (5'(gi) < w_end)
                             && (5'(gi) < {1'b0, i_limit});
        end
    endgenerate

    assign w_post    = r_bitmap | w_mask;
    assign o_adv     = w_post[0];
    assign w_next    = o_adv ? (w_post >> 1) : w_post;
    assign o_pop     = popcnt(r_bitmap);
    assign o_pop_nxt = popcnt(w_next);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitmap <= '0;
        end else begin
            r_bitmap <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcp_rcv_reasm.sv
`default_nettype none
// ============================================================================
// Module      : tcp_rcv_reasm
// Description : TCP receiver with out-of-order reassembly, in-order user
//               delivery and cumulative ACK generation.
//               Optional macro TCP_DELACK_EN enables delayed ACKs.
// Revision    : 1.0 - initial release
// ============================================================================
module tcp_rcv_reasm
    import tcp_pkg::*;
#(
    parameter int WIN      = 8,
    parameter int INIT_SEQ = 0,
    parameter int ACK_DLY  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       seg_val,
    input  logic [3:0] seg_seq,
    input  logic [3:0] seg_len,
    input  logic       usr_rd,
    output logic       data_rcv,
    output logic       buf_empty,
    output logic       rcv_ack,
    output logic [3:0] rcv_seq,
    output logic [3:0] rcv_buff
);

    localparam logic [3:0] c_win  = 4'(WIN);
    localparam seq_t       c_init = seq_t'(INIT_SEQ);

    generate
        if (WIN < 1 || WIN > 8 || ACK_DLY < 0 || ACK_DLY > 255) begin : g_bad_param
            $error("tcp_rcv_reasm: WIN must be 1..8 and ACK_DLY 0..255");
        end
    endgenerate

    seq_t       r_rcv_nxt;
    seq_t       w_rcv_nxt_nxt;
    seq_t       w_off;
    logic [3:0] r_in_buf;
    logic [3:0] w_in_buf_nxt;
    logic [3:0] w_limit;
    logic [3:0] w_pop;
    logic [3:0] w_pop_nxt;
    logic [3:0] w_avail;
    logic [3:0] w_avail_nxt;
    logic       w_adv;
    logic       w_forced;
    logic       w_rd;
    logic       w_reopen;
    logic       w_urgent;
    logic       w_issue;
    ack_state_t r_state;
    ack_state_t w_state_nxt;
    logic       r_data_rcv;
    logic       r_buf_empty;
    logic       r_ack;
    seq_t       r_ack_seq;
    logic [3:0] r_ack_buff;

    assign w_off   = seq_off(seg_seq, r_rcv_nxt);
    assign w_limit = c_win - r_in_buf;

    tcp_rcv_bitmap #(
        .WIN (WIN)
    ) u_bitmap (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_seg_val (seg_val),
        .i_off     (w_off),
        .i_len     (seg_len),
        .i_limit   (w_limit),
        .o_adv     (w_adv),
        .o_forced  (w_forced),
        .o_pop     (w_pop),
        .o_pop_nxt (w_pop_nxt)
    );

    assign w_rd          = usr_rd && (r_in_buf != '0);
    assign w_rcv_nxt_nxt = r_rcv_nxt + {3'b000, w_adv};

    always_comb begin
        w_in_buf_nxt = r_in_buf;
        if (w_adv && !w_rd) begin
            w_in_buf_nxt = r_in_buf + 4'd1;
        end else if (!w_adv && w_rd) begin
            w_in_buf_nxt = r_in_buf - 4'd1;
        end
    end

    assign w_avail     = c_win - r_in_buf - w_pop;
    assign w_avail_nxt = c_win - w_in_buf_nxt - w_pop_nxt;
    assign w_reopen    = (w_avail == '0) && (w_avail_nxt != '0);
    assign w_urgent    = w_forced || w_reopen;

`ifdef TCP_DELACK_EN
    localparam logic [7:0] c_dly = 8'(ACK_DLY);

    logic [7:0] r_dly_cnt;
    logic [7:0] w_dly_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dly_cnt <= '0;
        end else begin
            r_dly_cnt <= w_dly_nxt;
        end
    end
`endif

    // Triggers seen while PEND are covered by the ACK issued that cycle,
    // because the ACK samples the post-update sequence and window.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
`ifdef TCP_DELACK_EN
        w_dly_nxt   = r_dly_cnt;
`endif
        case (r_state)
            IDLE: begin
`ifdef TCP_DELACK_EN
                if (w_urgent
                    || (w_adv && ((r_dly_cnt != '0) || (c_dly == '0)))
                    || (r_dly_cnt == 8'd1)) begin
                    w_state_nxt = PEND;
                    w_dly_nxt   = '0;
                end else if (w_adv) begin
                    w_dly_nxt = c_dly;
                end else if (r_dly_cnt != '0) begin
                    w_dly_nxt = r_dly_cnt - 8'd1;
                end
`else
                if (w_urgent || w_adv) begin
                    w_state_nxt = PEND;
                end
`endif
            end
            PEND: begin
                w_state_nxt = IDLE;
                w_issue     = 1'b1;
`ifdef TCP_DELACK_EN
                w_dly_nxt   = '0;
`endif
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rcv_nxt   <= c_init;
            r_in_buf    <= '0;
            r_data_rcv  <= 1'b0;
            r_buf_empty <= 1'b1;
            r_ack       <= 1'b0;
            r_ack_seq   <= c_init;
            r_ack_buff  <= c_win;
        end else begin
            r_state     <= w_state_nxt;
            r_rcv_nxt   <= w_rcv_nxt_nxt;
            r_in_buf    <= w_in_buf_nxt;
            r_data_rcv  <= w_rd;
            r_buf_empty <= (w_in_buf_nxt == '0);
            r_ack       <= w_issue;
            if (w_issue) begin
                r_ack_seq  <= w_rcv_nxt_nxt;
                r_ack_buff <= w_avail_nxt;
            end
        end
    end

    assign data_rcv  = r_data_rcv;
    assign buf_empty = r_buf_empty;
    assign rcv_ack   = r_ack;
    assign rcv_seq   = r_ack_seq;
    assign rcv_buff  = r_ack_buff;

endmodule
`default_nettype wire

// File: tb/tb_tcp_rcv_reasm.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcp_rcv_reasm
// Description : Self-checking bench for tcp_rcv_reasm against a set-based
//               reference model of the receive window.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tcp_rcv_reasm;

    localparam int WIN     = 8;
    localparam int ACK_DLY = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       seg_val = 1'b0;
    logic [3:0] seg_seq = '0;
    logic [3:0] seg_len = '0;
    logic       usr_rd = 1'b0;
    logic       data_rcv, buf_empty, rcv_ack;
    logic [3:0] rcv_seq, rcv_buff;
    logic       data_rcv_w, buf_empty_w, rcv_ack_w;
    logic [3:0] rcv_seq_w, rcv_buff_w;

    tcp_rcv_reasm #(.WIN(WIN), .INIT_SEQ(0), .ACK_DLY(ACK_DLY)) dut (
        .clk(clk), .reset_n(reset_n), .seg_val(seg_val), .seg_seq(seg_seq),
        .seg_len(seg_len), .usr_rd(usr_rd), .data_rcv(data_rcv),
        .buf_empty(buf_empty), .rcv_ack(rcv_ack), .rcv_seq(rcv_seq), .rcv_buff(rcv_buff)
    );

    tcp_rcv_reasm #(.WIN(WIN), .INIT_SEQ(12), .ACK_DLY(ACK_DLY)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .seg_val(seg_val), .seg_seq(seg_seq),
        .seg_len(seg_len), .usr_rd(usr_rd), .data_rcv(data_rcv_w),
        .buf_empty(buf_empty_w), .rcv_ack(rcv_ack_w), .rcv_seq(rcv_seq_w), .rcv_buff(rcv_buff_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: set of received-but-unconsumed absolute sequence numbers.
    bit got [16];
    int m_nxt, m_inbuf, m_seq, m_buff, cyc, m_due;
    bit m_pend, m_timer, m_data, m_empty, m_ack;

    function automatic int m_avail();
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(got[i]);
        return WIN - m_inbuf - n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) got[i] = 1'b0;
        m_nxt = 0; m_inbuf = 0; m_pend = 0; m_timer = 0; m_due = 0;
        m_data = 0; m_empty = 1; m_ack = 0; m_seq = 0; m_buff = WIN;
    endtask

    task automatic model_clock(input bit val, input int seq, input int len, input bit rd);
        int  av0, off, lim, stop;
        bit  forced, adv, rd_ok, reopen;
        forced = 0; adv = 0;
        av0 = m_avail();
        lim = WIN - m_inbuf;
        if (val) begin
            off = (seq - m_nxt) & 15;
            if (len == 0 || off >= lim) forced = 1;
            else begin
                stop = (off + len > lim) ? lim : off + len;
                for (int k = off; k < stop; k++) got[(m_nxt + k) % 16] = 1'b1;
            end
        end
        rd_ok = rd && (m_inbuf > 0);
        if (got[m_nxt]) begin
            got[m_nxt] = 1'b0;
            m_nxt = (m_nxt + 1) % 16;
            adv = 1;
        end
        m_inbuf = m_inbuf + int'(adv) - int'(rd_ok);
        reopen = (av0 == 0) && (m_avail() != 0);
        m_data = rd_ok;
        m_empty = (m_inbuf == 0);
        m_ack = 0;
        if (m_pend) begin
            m_ack = 1; m_seq = m_nxt; m_buff = m_avail();
            m_pend = 0; m_timer = 0;
        end else begin
`ifdef TCP_DELACK_EN
            if (forced || reopen || (adv && m_timer) || (m_timer && cyc == m_due)
                || (adv && ACK_DLY == 0)) begin
                m_pend = 1; m_timer = 0;
            end else if (adv) begin
                m_timer = 1; m_due = cyc + ACK_DLY;
            end
`else
            if (adv || forced || reopen) m_pend = 1;
`endif
        end
    endtask

    task automatic step(input bit val, input int seq, input int len, input bit rd);
        seg_val = val; seg_seq = 4'(seq); seg_len = 4'(len); usr_rd = rd;
        @(posedge clk);
        model_clock(val, seq & 15, len & 15, rd);
        cyc++;
        #1;
        checks++;
        if (data_rcv !== m_data) begin
            errors++; $display("FAIL data_rcv cyc=%0d got %0b exp %0b", cyc, data_rcv, m_data);
        end
        checks++;
        if (buf_empty !== m_empty) begin
            errors++; $display("FAIL buf_empty cyc=%0d got %0b exp %0b", cyc, buf_empty, m_empty);
        end
        checks++;
        if (rcv_ack !== m_ack) begin
            errors++; $display("FAIL rcv_ack cyc=%0d got %0b exp %0b", cyc, rcv_ack, m_ack);
        end
        checks++;
        if (rcv_seq !== 4'(m_seq)) begin
            errors++; $display("FAIL rcv_seq cyc=%0d got %0d exp %0d", cyc, rcv_seq, m_seq);
        end
        checks++;
        if (rcv_buff !== 4'(m_buff)) begin
            errors++; $display("FAIL rcv_buff cyc=%0d got %0d exp %0d", cyc, rcv_buff, m_buff);
        end
        seg_val = 0; usr_rd = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        step(1, 0, 2, 0);
        @(negedge clk);
        reset_n = 0;
        model_reset();
        #1;
        checks++;
        if ({rcv_ack, data_rcv, buf_empty, rcv_seq, rcv_buff} !== {1'b0, 1'b0, 1'b1, 4'd0, 4'd8}) begin
            errors++; $display("FAIL reset_outputs got ack=%0b data=%0b empty=%0b seq=%0d buff=%0d exp 0 0 1 0 8",
                               rcv_ack, data_rcv, buf_empty, rcv_seq, rcv_buff);
        end
        checks++;
        if (rcv_seq_w !== 4'd12 || rcv_buff_w !== 4'd8) begin
            errors++; $display("FAIL reset_init_seq got seq=%0d buff=%0d exp 12 8", rcv_seq_w, rcv_buff_w);
        end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_in_order();
        do_reset();
        step(1, 0, 3, 0);
        idle(6);
        checks++;
        if (rcv_seq !== 4'd3 || rcv_buff !== 4'd5 || buf_empty !== 1'b0) begin
            errors++; $display("FAIL in_order got seq=%0d buff=%0d empty=%0b exp 3 5 0", rcv_seq, rcv_buff, buf_empty);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        step(1, 4, 2, 0);
        idle(3);
        checks++;
        if (buf_empty !== 1'b1 || rcv_seq !== 4'd0) begin
            errors++; $display("FAIL ooo_hold got empty=%0b seq=%0d exp 1 0", buf_empty, rcv_seq);
        end
        step(1, 0, 4, 0);
        idle(7);
        checks++;
        if (rcv_seq !== 4'd6 || rcv_buff !== 4'd2) begin
            errors++; $display("FAIL ooo_reasm got seq=%0d buff=%0d exp 6 2", rcv_seq, rcv_buff);
        end
    endtask

    task automatic test_duplicate();
        step(1, 2, 2, 0);
        step(0, 0, 0, 0);
        checks++;
        if (rcv_ack !== 1'b1 || rcv_seq !== 4'd6 || rcv_buff !== 4'd2) begin
            errors++; $display("FAIL dup_ack got ack=%0b seq=%0d buff=%0d exp 1 6 2", rcv_ack, rcv_seq, rcv_buff);
        end
        idle(2);
        step(1, 15, 1, 0);
        step(0, 0, 0, 0);
        checks++;
        if (rcv_ack !== 1'b1 || rcv_seq !== 4'd6 || rcv_buff !== 4'd2) begin
            errors++; $display("FAIL oow_ack got ack=%0b seq=%0d buff=%0d exp 1 6 2", rcv_ack, rcv_seq, rcv_buff);
        end
    endtask

    task automatic test_wrap_full();
        do_reset();
        step(1, 12, 8, 0);
        idle(9);
        checks++;
        if (rcv_seq_w !== 4'd4 || rcv_buff_w !== 4'd0 || buf_empty_w !== 1'b0) begin
            errors++; $display("FAIL wrap_full got seq=%0d buff=%0d empty=%0b exp 4 0 0", rcv_seq_w, rcv_buff_w, buf_empty_w);
        end
        step(0, 0, 0, 1);
        checks++;
        if (data_rcv_w !== 1'b1) begin
            errors++; $display("FAIL wrap_read got data_rcv=%0b exp 1", data_rcv_w);
        end
        step(0, 0, 0, 0);
        checks++;
        if (rcv_ack_w !== 1'b1 || rcv_buff_w !== 4'd1 || rcv_seq_w !== 4'd4) begin
            errors++; $display("FAIL wrap_reopen got ack=%0b buff=%0d seq=%0d exp 1 1 4", rcv_ack_w, rcv_buff_w, rcv_seq_w);
        end
    endtask

    task automatic test_clip();
        do_reset();
        step(1, 0, 6, 0);
        idle(7);
        step(1, 6, 5, 0);
        idle(5);
        checks++;
        if (rcv_seq !== 4'd8 || rcv_buff !== 4'd0) begin
            errors++; $display("FAIL clip got seq=%0d buff=%0d exp 8 0", rcv_seq, rcv_buff);
        end
    endtask

    task automatic test_ack_latency();
        int  lat;
        int  exp_lat;
        bit  seen;
`ifdef TCP_DELACK_EN
        exp_lat = ACK_DLY + 1;
`else
        exp_lat = 1;
`endif
        do_reset();
        step(1, 0, 1, 0);
        lat = -1; seen = 0;
        for (int i = 1; i <= 12 && !seen; i++) begin
            step(0, 0, 0, 0);
            if (rcv_ack === 1'b1) begin seen = 1; lat = i; end
        end
        checks++;
        if (lat != exp_lat) begin
            errors++; $display("FAIL ack_latency got %0d exp %0d", lat, exp_lat);
        end
        do_reset();
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        checks++;
`ifdef TCP_DELACK_EN
        if (rcv_ack !== 1'b1 || rcv_seq !== 4'd2) begin
            errors++; $display("FAIL ack_second_adv got ack=%0b seq=%0d exp 1 2", rcv_ack, rcv_seq);
        end
`else
        if (rcv_ack !== 1'b0 || rcv_seq !== 4'd2) begin
            errors++; $display("FAIL ack_merge got ack=%0b seq=%0d exp 0 2", rcv_ack, rcv_seq);
        end
`endif
    endtask

    task automatic test_random();
        int seq;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) seq = int'($urandom_range(0, 15));
            else seq = (m_nxt + int'($urandom_range(0, 9))) % 16;
            step($urandom_range(0, 1) == 1, seq, int'($urandom_range(0, 5)),
                 $urandom_range(0, 2) == 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0;
        model_reset();
        do_reset();
        test_reset();
        test_in_order();
        test_out_of_order();
        test_duplicate();
        test_wrap_full();
        test_clip();
        test_ack_latency();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
